// File: rtl/axi_cmd_pkg.sv
// Shared types and constants for the AXI command arbiter.
//   state_t : arbiter sequencing states
//   RESP_*  : AXI response codes returned to requesters
//   BURST_* : AXI burst type encodings
//   cmd_t   : one latched burst command (op, address, length, burst type)
package axi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Address width of the shared AXI master's wr_addr/rd_addr.
  localparam int CMD_ADDR_W = 24;

  typedef struct packed {
    logic                  wr;
    logic [CMD_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [1:0]            burst;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req         : request bits, one per requester
//   ptr         : highest-priority index for this pick
//   grant       : one-hot winner (zero when nothing requests)
//   grant_idx   : binary index of the winner
//   grant_valid : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Walk the requesters starting at ptr, wrapping past NUM_REQ-1; the first
  // hit wins and later hits are masked by grant_valid.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = 0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Shares one AXI master command port between NUM_REQ requesters. Commands are
// taken round-robin, issued one at a time, held until the master reports
// completion (or a watchdog expires), and the response is returned to the
// owning requester as a one-cycle req_done pulse.
//   m_axi_aclk / m_axi_areset : clock, async active-high reset
//   req_*   : per-requester command valid/ready, packed fields, done/resp
//   cmd_*   : command handshake, latched fields, completion from master
//   grant_id: owner of the current/last command; busy: not IDLE
//
// state     | meaning
// IDLE      | picking a requester, req_ready driven to the winner
// ISSUE     | cmd_valid high, waiting for cmd_ready
// WAIT_DONE | command in flight, watchdog timer running
// RESPOND   | one-cycle req_done/req_resp to the owner
module axi_cmd_arbiter
  import axi_cmd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = CMD_ADDR_W,
  parameter int TIMEOUT = 64
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_len,
  input  logic [NUM_REQ*2-1:0]      req_burst,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [1:0]                req_resp,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_wr,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [7:0]                cmd_len,
  output logic [1:0]                cmd_burst,
  input  logic                      cmd_done,
  input  logic [1:0]                cmd_resp,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);

  // cmd_t carries the master's fixed address width.
  if (ADDR_W != CMD_ADDR_W) begin : g_addr_w_check
    $error("axi_cmd_arbiter: ADDR_W must equal CMD_ADDR_W");
  end

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_id_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [1:0]           resp_q;
  cmd_t                 cmd_q;
  cmd_t                 pick_cmd;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 timed_out;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (pick_onehot),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_cmd.wr    = req_wr[i];
        pick_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_cmd.len   = req_len[i*8 +: 8];
        pick_cmd.burst = req_burst[i*2 +: 2];
      end
    end
  end

  assign timed_out = (timer_q == TIMER_LAST);

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick_valid) state_d = ISSUE;
      ISSUE:     if (cmd_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (cmd_done || timed_out) state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      timer_q    <= '0;
      resp_q     <= RESP_OKAY;
      cmd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            cmd_q      <= pick_cmd;
            grant_id_q <= pick_idx;
          end
        end
        ISSUE: begin
          if (cmd_ready) timer_q <= '0;
        end
        WAIT_DONE: begin
          // A real completion wins over the watchdog on the same cycle.
          if (cmd_done)       resp_q  <= cmd_resp;
          else if (timed_out) resp_q  <= RESP_DECERR;
          else                timer_q <= timer_q + TIMER_W'(1);
        end
        RESPOND: begin
          rr_ptr_q <= (grant_id_q == IDX_LAST) ? '0 : grant_id_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    req_done  = '0;
    req_resp  = RESP_OKAY;
    cmd_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      // Gated by reset so the async reset also clears the combinational ready.
      IDLE:      if (!m_axi_areset) req_ready = pick_onehot;
      ISSUE: begin
        cmd_valid = 1'b1;
        busy      = 1'b1;
      end
      WAIT_DONE: busy = 1'b1;
      RESPOND: begin
        busy     = 1'b1;
        req_resp = resp_q;
        for (int i = 0; i < NUM_REQ; i++) req_done[i] = (grant_id_q == IDX_W'(i));
      end
      default: ;
    endcase
  end

  assign cmd_wr    = cmd_q.wr;
  assign cmd_addr  = cmd_q.addr;
  assign cmd_len   = cmd_q.len;
  assign cmd_burst = cmd_q.burst;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
module tb_axi_cmd_arbiter;
  import axi_cmd_pkg::*;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*8-1:0]  req_len = '0;
  logic [N*2-1:0]  req_burst = '0;
  logic [N-1:0]    req_done;
  logic [1:0]      req_resp;
  logic            cmd_valid;
  logic            cmd_ready = 1'b0;
  logic            cmd_wr;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [1:0]      cmd_burst;
  logic            cmd_done = 1'b0;
  logic [1:0]      cmd_resp = 2'b00;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  axi_cmd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_burst(req_burst),
    .req_done(req_done), .req_resp(req_resp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .cmd_done(cmd_done), .cmd_resp(cmd_resp),
    .grant_id(grant_id), .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int cv_cnt   = 0;
  int done_cyc[$];
  int done_gid[$];
  int done_resp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Transaction-level model: one outstanding command with its owner, whether
  // the master has taken it, its wait age and a pending completion.
  bit         m_active, m_taken, m_fin;
  int         m_owner, m_ptr, m_age, pk;
  logic [1:0] m_resp;
  logic       m_wr;
  logic [AW-1:0] m_addr;
  logic [7:0] m_len;
  logic [1:0] m_burst;
  logic [N-1:0] exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_req_done", req_done, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      m_active = 0; m_taken = 0; m_fin = 0; m_owner = 0; m_ptr = 0; m_age = 0;
      m_resp = 0; m_wr = 0; m_addr = 0; m_len = 0; m_burst = 0;
    end else begin
      pk = m_active ? -1 : rr_pick(req_valid, m_ptr);
      exp_ready = (pk >= 0) ? (N'(1) << pk) : '0;
      chk("req_ready", req_ready, exp_ready);
      chk("cmd_valid", cmd_valid, m_active && !m_taken);
      chk("busy", busy, m_active);
      chk("req_done", req_done, m_fin ? (N'(1) << m_owner) : '0);
      chk("req_resp", req_resp, m_fin ? m_resp : 2'b00);
      chk("grant_id", grant_id, m_owner);
      chk("cmd_wr", cmd_wr, m_wr);
      chk("cmd_addr", cmd_addr, m_addr);
      chk("cmd_len", cmd_len, m_len);
      chk("cmd_burst", cmd_burst, m_burst);
      if (req_done != 0) begin
        done_cyc.push_back(cyc);
        done_gid.push_back(int'(grant_id));
        done_resp.push_back(int'(req_resp));
      end
      if (cmd_valid) cv_cnt++;
      if (m_fin) begin
        m_fin = 0; m_active = 0; m_ptr = (m_owner + 1) % N;
      end else if (!m_active) begin
        if (pk >= 0) begin
          m_active = 1; m_taken = 0; m_owner = pk;
          m_wr = req_wr[pk]; m_addr = req_addr[pk*AW +: AW];
          m_len = req_len[pk*8 +: 8]; m_burst = req_burst[pk*2 +: 2];
        end
      end else if (!m_taken) begin
        if (cmd_ready) begin m_taken = 1; m_age = 0; end
      end else begin
        if (cmd_done) begin m_fin = 1; m_resp = cmd_resp; end
        else if (m_age == TO - 1) begin m_fin = 1; m_resp = 2'b11; end
        else m_age++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [7:0] l, input logic [1:0] b);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_len[i*8 +: 8] = l;
    req_burst[i*2 +: 2] = b;
  endtask

  int base, w_cyc, cnt2;
  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (2) step();
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_addr", cmd_addr, 0);
    rst = 1'b0;
    step();

    // Round-robin with master always ready/done.
    for (int i = 0; i < N; i++) set_req(i, i[0], AW'(24'h001000 + i * 16), 8'(i + 1), BURST_INCR);
    base = done_gid.size();
    req_valid = 4'b1111; cmd_ready = 1; cmd_done = 1; cmd_resp = 2'b00;
    repeat (17) step();
    req_valid = 4'b0000;
    repeat (5) step();
    cmd_ready = 0; cmd_done = 0;
    chk("rr_count", done_gid.size() - base, 5);
    for (int k = 0; k < 5; k++)
      if (base + k < done_gid.size()) chk("rr_order", done_gid[base+k], exp_rr[k]);
    for (int k = 1; k < 5; k++)
      if (base + k < done_cyc.size()) chk("rr_gap", done_cyc[base+k] - done_cyc[base+k-1], 4);

    // Single request to requester 2.
    set_req(2, 1'b1, 24'h000100, 8'd4, BURST_INCR);
    base = done_gid.size(); cv_cnt = 0;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000; cmd_ready = 1;
    step();
    cmd_ready = 0;
    repeat (5) step();
    cmd_done = 1; cmd_resp = 2'b00;
    step();
    cmd_done = 0;
    repeat (3) step();
    chk("single_cmd_valid_cycles", cv_cnt, 1);
    chk("single_cmd_addr", cmd_addr, 24'h000100);
    chk("single_grant_id", grant_id, 2);
    cnt2 = 0;
    for (int k = base; k < done_gid.size(); k++) if (done_gid[k] == 2) cnt2++;
    chk("single_done_pulses", cnt2, 1);
    if (done_resp.size() > base) chk("single_resp", done_resp[base], 0);

    // Pointer at 3, only requester 1 -> 1; then 0 and 1 with pointer at 2 -> 0.
    set_req(1, 1'b0, 24'h00ABCD, 8'd7, BURST_WRAP);
    set_req(0, 1'b1, 24'h123456, 8'd2, BURST_FIXED);
    base = done_gid.size();
    cmd_ready = 1; cmd_done = 1;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    repeat (4) step();
    req_valid = 4'b0011;
    step();
    req_valid = 4'b0000;
    repeat (4) step();
    cmd_ready = 0; cmd_done = 0;
    chk("wrap_count", done_gid.size() - base, 2);
    if (done_gid.size() >= base + 2) begin
      chk("wrap_first", done_gid[base], 1);
      chk("wrap_second", done_gid[base+1], 0);
    end

    // Watchdog: no cmd_done at all.
    set_req(3, 1'b0, 24'hFFFF00, 8'd255, BURST_INCR);
    base = done_gid.size();
    req_valid = 4'b1000; cmd_ready = 1;
    step();
    req_valid = 4'b0000;
    step();
    w_cyc = cyc; cmd_ready = 0;
    repeat (70) step();
    chk("timeout_count", done_gid.size() - base, 1);
    if (done_gid.size() > base) begin
      chk("timeout_latency", done_cyc[base] - w_cyc, 64);
      chk("timeout_resp", done_resp[base], 3);
      chk("timeout_gid", done_gid[base], 3);
    end
    chk("timeout_idle", busy, 0);

    // cmd_done on the last watchdog cycle wins.
    base = done_gid.size();
    req_valid = 4'b0001; cmd_ready = 1;
    step();
    req_valid = 4'b0000;
    step();
    w_cyc = cyc; cmd_ready = 0;
    repeat (63) step();
    cmd_done = 1; cmd_resp = 2'b10;
    step();
    cmd_done = 0; cmd_resp = 2'b00;
    repeat (3) step();
    chk("race_count", done_gid.size() - base, 1);
    if (done_gid.size() > base) begin
      chk("race_resp", done_resp[base], 2);
      chk("race_latency", done_cyc[base] - w_cyc, 64);
    end

    // Reset while a command is waiting for completion.
    req_valid = 4'b0010; cmd_ready = 1;
    step();
    req_valid = 4'b0000;
    step();
    cmd_ready = 0;
    repeat (3) step();
    base = done_gid.size();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_req_done", req_done, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_cmd_addr", cmd_addr, 0);
    step();
    step();
    rst = 1'b0;
    chk("midrst_no_done", done_gid.size() - base, 0);
    req_valid = 4'b1001;
    #1;
    chk("midrst_first_ready", req_ready, 4'b0001);
    cmd_ready = 1; cmd_done = 1;
    step();
    req_valid = 4'b0000;
    repeat (4) step();
    cmd_ready = 0; cmd_done = 0;
    chk("midrst_next_count", done_gid.size() - base, 1);
    if (done_gid.size() > base) chk("midrst_next_gid", done_gid[base], 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
